// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_stage_pkg
// Purpose : Shared definitions for the ID/EX pipeline register: control-word
//           layout, bubble constant and ALU no-operation code.
// Ports   : n/a (package)
// Rev     : 1.0  initial release
// ============================================================================
package id_ex_stage_pkg;

  // Control word layout, MSB first:
  // {regwrite, memtoreg, memwrite, alusrc, regdst, jump, branch,
  //  branch_condition[1:0], alucontrol[3:0]}
  localparam int CTRL_W        = 13;
  localparam int CTRL_REGWRITE = 12;
  localparam int CTRL_MEMTOREG = 11;
  localparam int CTRL_MEMWRITE = 10;
  localparam int CTRL_ALUSRC   = 9;
  localparam int CTRL_REGDST   = 8;
  localparam int CTRL_JUMP     = 7;
  localparam int CTRL_BRANCH   = 6;
  localparam int CTRL_BCOND_HI = 5;
  localparam int CTRL_BCOND_LO = 4;
  localparam int CTRL_ALU_HI   = 3;
  localparam int CTRL_ALU_LO   = 0;

  localparam logic [3:0]        EXE_NO_OPERATION = 4'b0000;
  // All-zero word: no writes, no branch/jump, ALU does nothing.
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE      = 13'b0;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic       jump;
    logic       branch;
    logic [1:0] branch_condition;
    logic [3:0] alucontrol;
  } ctrl_t;

  function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] c);
    ctrl_t f;
    f = ctrl_t'(c);
    return f.memtoreg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_stage_if
// Purpose : Bundles the decode-side inputs, execute-side outputs and the
//           stall/flush/hold controls of the ID/EX pipeline register.
// Ports   : modport master - decode/hazard logic driving the stage
//           modport slave  - the id_ex_stage itself
// Rev     : 1.0  initial release
// ============================================================================
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [CTRL_W-1:0] ctrl_decode;
  logic              valid_decode;
  logic [DATA_W-1:0] rd1_decode;
  logic [DATA_W-1:0] rd2_decode;
  logic [DATA_W-1:0] signimm_decode;
  logic [DATA_W-1:0] pc_plus4_decode;
  logic [REG_AW-1:0] rs_decode;
  logic [REG_AW-1:0] rt_decode;
  logic [REG_AW-1:0] rd_decode;
  logic [REG_AW-1:0] shamt_decode;
  logic              flush_execute;
  logic              hold_execute;

  logic [CTRL_W-1:0] ctrl_execute;
  logic              valid_execute;
  logic [DATA_W-1:0] rd1_execute;
  logic [DATA_W-1:0] rd2_execute;
  logic [DATA_W-1:0] signimm_execute;
  logic [DATA_W-1:0] pc_plus4_execute;
  logic [REG_AW-1:0] rs_execute;
  logic [REG_AW-1:0] rt_execute;
  logic [REG_AW-1:0] rd_execute;
  logic [REG_AW-1:0] shamt_execute;
  logic              stall_fetch;
  logic              stall_decode;
  logic [CNT_W-1:0]  bubble_count;

  modport master (
    output ctrl_decode, valid_decode, rd1_decode, rd2_decode, signimm_decode,
           pc_plus4_decode, rs_decode, rt_decode, rd_decode, shamt_decode,
           flush_execute, hold_execute,
    input  ctrl_execute, valid_execute, rd1_execute, rd2_execute,
           signimm_execute, pc_plus4_execute, rs_execute, rt_execute,
           rd_execute, shamt_execute, stall_fetch, stall_decode, bubble_count
  );

  modport slave (
    input  ctrl_decode, valid_decode, rd1_decode, rd2_decode, signimm_decode,
           pc_plus4_decode, rs_decode, rt_decode, rd_decode, shamt_decode,
           flush_execute, hold_execute,
    output ctrl_execute, valid_execute, rd1_execute, rd2_execute,
           signimm_execute, pc_plus4_execute, rs_execute, rt_execute,
           rd_execute, shamt_execute, stall_fetch, stall_decode, bubble_count
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module  : load_use_detect
// Purpose : Combinational load-use hazard detector. Flags a decode
//           instruction that reads the destination of a load now in execute.
// Ports   : i_valid_execute, i_memtoreg_execute, i_rt_execute - EX slot
//           i_valid_decode, i_rs_decode, i_rt_decode           - ID slot
//           o_lu                                               - hazard
// Rev     : 1.0  initial release
// ============================================================================
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  wire logic              i_valid_execute,
  input  wire logic              i_memtoreg_execute,
  input  wire logic [REG_AW-1:0] i_rt_execute,
  input  wire logic              i_valid_decode,
  input  wire logic [REG_AW-1:0] i_rs_decode,
  input  wire logic [REG_AW-1:0] i_rt_decode,
  output logic                   o_lu
);
  logic w_addr_match;

  // r0 is hardwired to zero, so a load into it never creates a dependency.
  assign w_addr_match = (i_rt_execute != '0) &&
                        ((i_rt_execute == i_rs_decode) ||
                         (i_rt_execute == i_rt_decode));

  assign o_lu = i_valid_execute & i_memtoreg_execute & i_valid_decode &
                w_addr_match;
endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_stage
// Purpose : ID/EX pipeline register with load-use stall, branch flush,
//           downstream hold and a saturating bubble counter.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - id_ex_stage_if.slave (decode in, execute out, controls)
// Rev     : 1.0  initial release
// ============================================================================
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input wire logic     clk,
  input wire logic     rst_n,
  id_ex_stage_if.slave bus
);
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_valid;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_signimm;
  logic [DATA_W-1:0] r_pc_plus4;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic [REG_AW-1:0] r_shamt;
  logic [CNT_W-1:0]  r_bubble_count;

  logic w_lu;
  logic w_bubble;

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .i_valid_execute    (r_valid),
    .i_memtoreg_execute (ctrl_is_load(r_ctrl)),
    .i_rt_execute       (r_rt),
    .i_valid_decode     (bus.valid_decode),
    .i_rs_decode        (bus.rs_decode),
    .i_rt_decode        (bus.rt_decode),
    .o_lu               (w_lu)
  );

  // Hold outranks everything; below it a flush or hazard loads a bubble.
  assign w_bubble = bus.flush_execute | w_lu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl     <= CTRL_BUBBLE;
      r_valid    <= 1'b0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_signimm  <= '0;
      r_pc_plus4 <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_shamt    <= '0;
    end else if (!bus.hold_execute) begin
      if (w_bubble) begin
        r_ctrl     <= CTRL_BUBBLE;
        r_valid    <= 1'b0;
        r_rd1      <= '0;
        r_rd2      <= '0;
        r_signimm  <= '0;
        r_pc_plus4 <= '0;
        r_rs       <= '0;
        r_rt       <= '0;
        r_rd       <= '0;
        r_shamt    <= '0;
      end else begin
        r_ctrl     <= bus.valid_decode ? bus.ctrl_decode : CTRL_BUBBLE;
        r_valid    <= bus.valid_decode;
        r_rd1      <= bus.rd1_decode;
        r_rd2      <= bus.rd2_decode;
        r_signimm  <= bus.signimm_decode;
        r_pc_plus4 <= bus.pc_plus4_decode;
        r_rs       <= bus.rs_decode;
        r_rt       <= bus.rt_decode;
        r_rd       <= bus.rd_decode;
        r_shamt    <= bus.shamt_decode;
      end
    end
  end

  // Only hazard bubbles are counted; a coincident flush wins and counts none.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_count <= '0;
    end else if (!bus.hold_execute && !bus.flush_execute && w_lu &&
                 (r_bubble_count != {CNT_W{1'b1}})) begin
      r_bubble_count <= r_bubble_count + 1'b1;
    end
  end

  assign bus.ctrl_execute     = r_ctrl;
  assign bus.valid_execute    = r_valid;
  assign bus.rd1_execute      = r_rd1;
  assign bus.rd2_execute      = r_rd2;
  assign bus.signimm_execute  = r_signimm;
  assign bus.pc_plus4_execute = r_pc_plus4;
  assign bus.rs_execute       = r_rs;
  assign bus.rt_execute       = r_rt;
  assign bus.rd_execute       = r_rd;
  assign bus.shamt_execute    = r_shamt;
  assign bus.stall_fetch      = w_lu | bus.hold_execute;
  assign bus.stall_decode     = w_lu | bus.hold_execute;
  assign bus.bubble_count     = r_bubble_count;
endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between decode and execute in the 5-stage MIPS core. It captures the decode control word and decoded operands each cycle and detects load-use hazards. On a hazard it stalls fetch/decode and inserts a bubble. It also applies branch/jump flushes and external holds, and counts inserted bubbles for performance monitoring.

## Interface
Parameters:
- DATA_W, 32, operand/PC width
- REG_AW, 5, register-address width
- CNT_W, 16, bubble-counter width

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ctrl_decode  input  13  packed control word {regwrite, memtoreg, memwrite, alusrc, regdst, jump, branch, branch_condition[1:0], alucontrol[3:0]}
- valid_decode  input  1  decode slot holds a real instruction
- rd1_decode, rd2_decode  input  DATA_W each  register-file read data
- signimm_decode  input  DATA_W  sign-extended immediate
- pc_plus4_decode  input  DATA_W  PC+4 of the decode instruction
- rs_decode, rt_decode, rd_decode, shamt_decode  input  REG_AW each  instruction fields
- flush_execute  input  1  branch/jump redirect; kill the instruction entering execute
- hold_execute  input  1  downstream (memory) wait; freeze this stage
- ctrl_execute  output  13  registered control word
- valid_execute  output  1  execute slot holds a real instruction
- rd1/rd2/signimm/pc_plus4/rs/rt/rd/shamt_execute  output  matching widths  registered copies of the decode fields
- stall_fetch, stall_decode  output  1 each  hold PC and IF/ID
- bubble_count  output  CNT_W  saturating count of load-use bubbles

## Operation
- Load-use hazard (combinational) is `lu`:
  - Condition: valid_execute & memtoreg_execute & valid_decode & (rt_execute != 0) & (rt_execute == rs_decode | rt_execute == rt_decode).
- stall_fetch = stall_decode = lu | hold_execute. Both are combinational.
- Register update per rising edge, in priority order:
  1. hold_execute = 1: all registers keep their value. bubble_count is unchanged.
  2. flush_execute = 1: load a bubble, i.e. ctrl = 0, valid = 0, all data fields 0. bubble_count is unchanged.
  3. lu = 1: load a bubble. bubble_count increments, saturating at 2^CNT_W-1.
  4. Otherwise: capture all decode fields. valid_execute = valid_decode. ctrl_execute = ctrl_decode if valid_decode, else 0.
- A bubble's control word is all zeros: no regwrite, no memwrite, no branch/jump, alucontrol = no-operation (4'b0000).
- Loads and stores are never issued while flush or hold is asserted on that edge.
- A flush coincident with lu counts no bubble, because flush has priority.

## Timing
- Latency: decode fields appear on *_execute one cycle after the capturing edge.
- Load-use costs exactly one bubble. On the cycle after the bubble, memtoreg_execute = 0, so lu drops and the stalled instruction is captured.
- The stall outputs have no registered delay; they are valid in the same cycle as the inputs.
- Reset (asynchronous, any time, including mid-stall):
  - ctrl_execute = 0, valid_execute = 0.
  - All data outputs = 0.
  - bubble_count = 0.
  - stall_fetch and stall_decode follow their equations, which evaluate to 0 when hold_execute = 0.
- Release from reset is synchronous to clk. The first capture happens on the first rising edge with rst_n high.

## Structure
- Shared package (extend the existing defines):
  - The control-word field offsets and CTRL_W = 13.
  - The bubble constant CTRL_BUBBLE = 13'b0.
  - EXE_NO_OPERATION.
- One sub-module, `load_use_detect`: purely combinational, produces lu from the execute and decode fields.
- The register bank and bubble counter live in `id_ex_stage` itself.

## Test plan
- Reset mid-stream: drive valid traffic, pulse rst_n low mid-cycle -> all outputs 0 immediately; capture resumes on the first edge after release.
- Normal flow: add r3,r1,r2 with rd1 = 5, rd2 = 7, ctrl = R-type/ADD -> next cycle ctrl_execute matches, rd1_execute = 5, valid_execute = 1, no stall.
- Load-use, rs match: lw r4 in EX, then add r5,r4,r1 in decode -> stalls = 1 for one cycle; a bubble enters EX; bubble_count 0 -> 1; add captured the following cycle.
- Load-use on r0: lw r0 in EX, then decode using r0 -> no stall, bubble_count unchanged.
- Flush vs hazard: lw r4 in EX, dependent instruction in decode, flush_execute = 1 on the same edge -> bubble loaded, bubble_count unchanged.
- Hold priority and saturation:
  - hold_execute = 1 with flush_execute = 1 for 3 cycles -> outputs frozen, stalls = 1.
  - Preload bubble_count to 16'hFFFF, force another load-use -> count stays 16'hFFFF.
